// File: rtl/tff_pkg.sv
`timescale 1ns/1ps
// Shared mode encoding for the T-flip-flop counter family.
// Pure definitions: no logic, no latency, no flow control.
package tff_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD   = 2'b00;
  localparam mode_t MODE_UP     = 2'b01;
  localparam mode_t MODE_DOWN   = 2'b10;
  localparam mode_t MODE_TOGGLE = 2'b11;

endpackage

// File: rtl/tff_cell.sv
`timescale 1ns/1ps
// One-bit T flip-flop, async active-low reset to 0; toggles on t.
// Latency one clk edge; no backpressure.
module tff_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tff_counter.sv
`timescale 1ns/1ps
// WIDTH-bit bank of T cells: hold/up/down/toggle-mask with load, modulus MAX_VAL+1, wrap or saturate.
// q and wrap update one clk after inputs; tc is combinational; no backpressure.
module tff_counter
  import tff_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (2**WIDTH) - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_mask,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MAX_VAL);
  localparam longint unsigned  LIMIT = (longint'(1) << WIDTH) - longint'(1);
  localparam bit               MAX_OK = (MAX_VAL >= 1) && (longint'(MAX_VAL) <= LIMIT);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] t;
  logic             wrap_next;
  mode_t            mode_s;

  assign mode_s = mode_t'(mode);

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    tog       = q ^ t_mask;
    if (load) begin
      q_next = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      case (mode_s)
        MODE_UP: begin
          if (q != MAXV) begin
            q_next = q + WIDTH'(1);
          end else if (!SATURATE) begin
            q_next    = '0;
            wrap_next = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q != '0) begin
            q_next = q - WIDTH'(1);
          end else if (!SATURATE) begin
            q_next    = MAXV;
            wrap_next = 1'b1;
          end
        end
        MODE_TOGGLE: begin
          q_next = (tog > MAXV) ? MAXV : tog;
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  // Every state change, including load and clamp, reaches q only as per-bit toggles.
  assign t = q_next ^ q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .t     (t[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap <= 1'b0;
    end else begin
      wrap <= wrap_next;
    end
  end

  assign tc = ((mode_s == MODE_UP)   && (q == MAXV)) ||
              ((mode_s == MODE_DOWN) && (q == '0));

  always_ff @(posedge clk) begin
    assert (MAX_OK) else $error("tff_counter: MAX_VAL out of range for WIDTH");
  end

endmodule

// File: tb/tb_tff_counter.sv
`timescale 1ns/1ps
// Bench for tff_counter: three configurations driven in parallel, checked every cycle against an arithmetic model.
module tb_tff_counter;

  localparam int NDUT = 3;
  localparam int WD[NDUT]  = '{8, 4, 4};
  localparam int MX[NDUT]  = '{255, 9, 9};
  localparam bit SAT[NDUT] = '{1'b0, 1'b0, 1'b1};

  logic       clk;
  logic       rst_n;
  logic       en       [NDUT];
  logic [1:0] mode     [NDUT];
  logic [7:0] t_mask   [NDUT];
  logic       load     [NDUT];
  logic [7:0] load_val [NDUT];
  logic       tc_o     [NDUT];
  logic       wrap_o   [NDUT];
  logic [7:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  chk_on = 1'b0;
  int  mq [NDUT];
  bit  mw [NDUT];

  tff_counter #(.WIDTH(8), .MAX_VAL(255), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .en(en[0]), .mode(mode[0]), .t_mask(t_mask[0]),
    .load(load[0]), .load_val(load_val[0]), .q(q0), .tc(tc_o[0]), .wrap(wrap_o[0]));

  tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en[1]), .mode(mode[1]), .t_mask(t_mask[1][3:0]),
    .load(load[1]), .load_val(load_val[1][3:0]), .q(q1), .tc(tc_o[1]), .wrap(wrap_o[1]));

  tff_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en[2]), .mode(mode[2]), .t_mask(t_mask[2][3:0]),
    .load(load[2]), .load_val(load_val[2][3:0]), .q(q2), .tc(tc_o[2]), .wrap(wrap_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int qv(int d);
    case (d)
      0:       return int'(q0);
      1:       return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  task automatic check(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: counts modulo MAX+1, or clamps to [0, MAX] when saturating.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < NDUT; d++) begin
        mq[d] = 0;
        mw[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < NDUT; d++) begin
        int m, lv, tm, nq;
        bit nw;
        m  = MX[d];
        lv = int'(load_val[d]) % (1 << WD[d]);
        tm = int'(t_mask[d]) % (1 << WD[d]);
        nq = mq[d];
        nw = 1'b0;
        if (load[d]) begin
          nq = (lv > m) ? m : lv;
        end else if (en[d]) begin
          case (mode[d])
            2'b01: begin
              if (SAT[d]) nq = (mq[d] + 1 > m) ? m : mq[d] + 1;
              else begin
                nw = (mq[d] == m);
                nq = (mq[d] + 1) % (m + 1);
              end
            end
            2'b10: begin
              if (SAT[d]) nq = (mq[d] - 1 < 0) ? 0 : mq[d] - 1;
              else begin
                nw = (mq[d] == 0);
                nq = (mq[d] + m) % (m + 1);
              end
            end
            2'b11: nq = ((mq[d] ^ tm) > m) ? m : (mq[d] ^ tm);
            default: nq = mq[d];
          endcase
        end
        mq[d] = nq;
        mw[d] = nw;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < NDUT; d++) begin
        bit etc;
        etc = ((mode[d] == 2'b01) && (mq[d] == MX[d])) || ((mode[d] == 2'b10) && (mq[d] == 0));
        check($sformatf("model_q%0d", d), qv(d), mq[d]);
        check($sformatf("model_wrap%0d", d), int'(wrap_o[d]), int'(mw[d]));
        check($sformatf("model_tc%0d", d), int'(tc_o[d]), int'(etc));
      end
    end
  end

  // Returns just after a falling edge, so outputs reflect the preceding rising edge.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_in(int d, bit l, int lv, bit e, int m, int tm);
    load[d]     = l;
    load_val[d] = 8'(lv);
    en[d]       = e;
    mode[d]     = 2'(m);
    t_mask[d]   = 8'(tm);
  endtask

  task automatic idle_all();
    for (int d = 0; d < NDUT; d++) set_in(d, 1'b0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    idle_all();
    #1 rst_n = 1'b0;
    mode[0] = 2'b10;
    #2;
    check("rst_q0", qv(0), 0);
    check("rst_wrap0", int'(wrap_o[0]), 0);
    check("rst_tc_down", int'(tc_o[0]), 1);
    idle_all();
    cyc();
    cyc();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Count 5 then reset between edges.
    set_in(0, 1'b0, 0, 1'b1, 1, 0);
    repeat (5) cyc();
    check("mid_q_before_rst", qv(0), 5);
    set_in(0, 1'b0, 0, 1'b0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("mid_q_after_rst", qv(0), 0);
    check("mid_wrap_after_rst", int'(wrap_o[0]), 0);
    cyc();
    rst_n = 1'b1;

    // Hold in down mode at 0, then one down edge wraps to 255.
    set_in(0, 1'b0, 0, 1'b0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_q", qv(0), 0);
      check("hold_tc", int'(tc_o[0]), 1);
    end
    set_in(0, 1'b0, 0, 1'b1, 2, 0);
    cyc();
    check("dwrap_q", qv(0), 255);
    check("dwrap_pulse", int'(wrap_o[0]), 1);
    set_in(0, 1'b0, 0, 1'b0, 2, 0);
    cyc();
    check("dwrap_pulse_end", int'(wrap_o[0]), 0);
    idle_all();

    // Up wrap at modulus 10.
    set_in(1, 1'b1, 8, 1'b0, 0, 0);
    cyc();
    check("uwrap_load", qv(1), 8);
    set_in(1, 1'b0, 0, 1'b1, 1, 0);
    cyc();
    check("uwrap_q9", qv(1), 9);
    check("uwrap_tc9", int'(tc_o[1]), 1);
    check("uwrap_nowrap9", int'(wrap_o[1]), 0);
    cyc();
    check("uwrap_q0", qv(1), 0);
    check("uwrap_pulse", int'(wrap_o[1]), 1);
    cyc();
    check("uwrap_q1", qv(1), 1);
    check("uwrap_pulse_end", int'(wrap_o[1]), 0);

    // Saturating down.
    set_in(2, 1'b1, 2, 1'b0, 0, 0);
    cyc();
    set_in(2, 1'b0, 0, 1'b1, 2, 0);
    cyc();
    check("sat_q1", qv(2), 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("sat_q0", qv(2), 0);
      check("sat_tc", int'(tc_o[2]), 1);
      check("sat_nowrap", int'(wrap_o[2]), 0);
    end
    idle_all();

    // Toggle mask and clamp.
    set_in(1, 1'b1, 3, 1'b0, 0, 0);
    cyc();
    set_in(1, 1'b0, 0, 1'b1, 3, 5);
    cyc();
    check("tog_q6", qv(1), 6);
    cyc();
    check("tog_q3", qv(1), 3);
    set_in(1, 1'b1, 8, 1'b1, 3, 5);
    cyc();
    check("tog_load8", qv(1), 8);
    set_in(1, 1'b0, 0, 1'b1, 3, 3);
    cyc();
    check("tog_clamp", qv(1), 9);

    // Load priority and load clamp.
    set_in(1, 1'b1, 15, 1'b0, 0, 0);
    cyc();
    check("load_clamp", qv(1), 9);
    set_in(1, 1'b1, 4, 1'b1, 1, 0);
    cyc();
    check("load_wins_q", qv(1), 4);
    check("load_wins_wrap", int'(wrap_o[1]), 0);
    idle_all();
    cyc();

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        load[d]     = ($urandom_range(7) == 0);
        load_val[d] = 8'($urandom);
        en[d]       = ($urandom_range(3) != 0);
        mode[d]     = 2'($urandom);
        t_mask[d]   = 8'($urandom);
      end
      if ($urandom_range(499) == 0) begin
        #1 rst_n = 1'b0;
        #1;
        check("rnd_rst_q0", qv(0), 0);
        check("rnd_rst_q1", qv(1), 0);
        rst_n = 1'b1;
      end
      cyc();
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of T-flip-flop cells driven by per-bit toggle enables.
- Modes: hold, up-count, down-count and raw toggle-mask, plus a synchronous parallel load.
- Configurable modulus (MAX_VAL) and wrap or saturate policy, with terminal-count and wrap-event flags.
- Used as a general event counter, divider or toggle register in control datapaths.

Parameters:
- WIDTH, 8, counter and mask width in bits (>= 1).
- MAX_VAL, 2**WIDTH-1, largest count value; the modulus is MAX_VAL+1. Must be >= 1 and <= 2**WIDTH-1.
- SATURATE, 0, 0 = wrap at the limits; 1 = stick at the limits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count/toggle enable; has no effect on load.
- mode  in  2  00 hold, 01 up, 10 down, 11 toggle-mask.
- t_mask  in  WIDTH  per-bit toggle enables used in mode 11.
- load  in  1  synchronous parallel load strobe.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  registered count/state.
- tc  out  1  terminal count, combinational from q and mode.
- wrap  out  1  registered single-cycle pulse.

Behaviour:
- Reset: rst_n low asynchronously forces q=0 and wrap=0. While reset is held, tc follows its equation, so tc=1 when mode=10. Deassertion takes effect at the first clk edge after rst_n goes high.
- Next-state priority per edge: load, then en, then mode.
  - load=1: q <= min(load_val, MAX_VAL); wrap <= 0. This happens regardless of en or mode.
  - en=0 or mode=00: q holds; wrap <= 0.
- Mode 01 (up):
  - q < MAX_VAL: q <= q+1.
  - q == MAX_VAL: if SATURATE=0, q <= 0 and wrap <= 1 on the same edge. If SATURATE=1, q holds and wrap <= 0.
- Mode 10 (down):
  - q > 0: q <= q-1.
  - q == 0: if SATURATE=0, q <= MAX_VAL and wrap <= 1. If SATURATE=1, q holds and wrap <= 0.
- Mode 11 (toggle-mask):
  - q <= q XOR t_mask; wrap <= 0.
  - If the result exceeds MAX_VAL, q <= MAX_VAL (clamp). No clamp is needed when MAX_VAL = 2**WIDTH-1.
- Implementation rule: the next state is formed only as per-bit toggle enables T[i] = q_next[i] XOR q[i], applied to tff_cell instances. This includes load, wrap and clamp cases. No direct D-path on q.
- tc equation:
  - tc = 1 when (mode==01 and q==MAX_VAL) or (mode==10 and q==0); else 0.
  - tc ignores en and load.
- wrap:
  - High for exactly one cycle after each wrapping edge; back-to-back wraps give consecutive pulses.
  - Never asserted when SATURATE=1 or in modes 00/11.
- Arithmetic: all compares are unsigned at WIDTH bits. MAX_VAL is truncated to WIDTH bits at elaboration; an assertion flags an out-of-range MAX_VAL.
- Mid-operation events:
  - A mode change takes effect on the next edge, with no pipeline state.
  - Reset asserted mid-count clears q and wrap immediately, independent of clk.
- Latency: one cycle from inputs to q and wrap.

Decomposition:
- Shared package tff_pkg:
  - mode encoding constants MODE_HOLD=2'b00, MODE_UP=2'b01, MODE_DOWN=2'b10, MODE_TOGGLE=2'b11;
  - a typedef for the 2-bit mode field.
- Sub-module tff_cell: a one-bit T flip-flop with async active-low reset to 0 (ports clk, rst_n, t, q). Instantiated WIDTH times by a generate loop.
- The top level holds next-state, toggle-enable, tc and wrap logic.

Test Plan:
- Reset mid-count (WIDTH=8): reset with mode=01, en=1, drive 5 edges, then pull rst_n low between edges. Required: q=5 before reset; q=0 and wrap=0 immediately after, with no clk edge.
- Wrap up (WIDTH=4, MAX_VAL=9, SATURATE=0): load 8, then up for 3 edges. Required: q sequence 9, 0, 1; tc=1 while q=9; wrap=1 only in the cycle q=0.
- Saturate down (WIDTH=4, MAX_VAL=9, SATURATE=1): load 2, then down for 4 edges. Required: q sequence 1, 0, 0, 0; tc=1 while q=0; wrap never asserts.
- Toggle and clamp (WIDTH=4, MAX_VAL=9): load 3, then mode=11 with t_mask=4'b0101 for 2 edges. Required: q=6, then q=3. Next, load 8 and apply t_mask=4'b0011. Required: q=9, since 11 is clamped.
- Priority and load clamp: load=1 with en=0 and load_val=15 (MAX_VAL=9). Required: q=9. Then load=1 with mode=01 and en=1 at q=9. Required: load wins, wrap=0.
- Hold and down wrap (WIDTH=8, default MAX_VAL, SATURATE=0): at q=0, en=0 and mode=10 for 3 edges. Required: q=0 throughout, tc=1. Then en=1 for one edge. Required: q=255 and a one-cycle wrap pulse.
